// File: rtl/grid_step_sequencer_if.sv
// ---------------------------------------------------------------------------
// grid_step_sequencer_if
// Port bundle between the grid sequencer and the single-port occupancy RAM.
//   ram_addr  : cell address y*40 + x (11 bits)
//   ram_we    : write enable
//   ram_wdata : write data (1 = occupied)
//   ram_rdata : read data, valid one cycle after ram_addr
// Modports:
//   master : the sequencer, which drives the address and write controls
//   slave  : the RAM, which returns the read data
// ---------------------------------------------------------------------------
interface grid_step_sequencer_if;
  logic [10:0] ram_addr;
  logic        ram_we;
  logic        ram_wdata;
  logic        ram_rdata;

  modport master (output ram_addr, ram_we, ram_wdata, input ram_rdata);
  modport slave  (input ram_addr, ram_we, ram_wdata, output ram_rdata);
endinterface

// File: rtl/grid_step_sequencer.sv
// ---------------------------------------------------------------------------
// grid_step_sequencer
// Owns the 40x30 one-bit occupancy grid RAM. The VGA scan reader and the
// per-move game update share it. During the active display region the VGA
// reader always gets the RAM and the move FSM waits. During blanking the FSM
// reads the new head cell, decides whether the move collides, writes the new
// head and clears the old tail. After reset the whole grid is swept to 0
// before any move is accepted.
// Ports:
//   clk_25M, rst            : clock; synchronous active-low reset
//   display_active          : 1 = VGA owns the RAM this cycle
//   pixel_x/pixel_y         : cell being scanned by VGA
//   pixel_data              : registered occupancy of the scanned cell
//   step                    : one-cycle move request
//   next_x/next_y           : new head cell
//   tail_x/tail_y           : current tail cell
//   grow                    : apple eaten; the tail stays in place
//   ram                     : RAM bus (master side)
//   init_done               : clear sweep complete
//   busy                    : move in progress
//   step_done               : one-cycle pulse at the end of a move
//   collide                 : move was fatal; valid with step_done
//   overrun                 : sticky; a step arrived that could not be taken
// ---------------------------------------------------------------------------
module grid_step_sequencer #(
  parameter int WIDTH  = 40,
  parameter int HEIGHT = 30,
  parameter int CELLS  = WIDTH * HEIGHT
) (
  input  logic                 clk_25M,
  input  logic                 rst,
  input  logic                 display_active,
  input  logic [5:0]           pixel_x,
  input  logic [5:0]           pixel_y,
  output logic                 pixel_data,
  input  logic                 step,
  input  logic [5:0]           next_x,
  input  logic [5:0]           next_y,
  input  logic [5:0]           tail_x,
  input  logic [5:0]           tail_y,
  input  logic                 grow,
  grid_step_sequencer_if.master ram,
  output logic                 init_done,
  output logic                 busy,
  output logic                 step_done,
  output logic                 collide,
  output logic                 overrun
);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_RD, S_CHK, S_WR_HEAD, S_CLR_TAIL, S_DONE
  } state_t;

  localparam logic [10:0] SWEEP_LAST = 11'(CELLS - 1);
  localparam logic [5:0]  X_LIMIT    = 6'(WIDTH);
  localparam logic [5:0]  Y_LIMIT    = 6'(HEIGHT);

  // y*40 + x as two shifts and an add.
  function automatic logic [10:0] cell_addr(input logic [5:0] x, input logic [5:0] y);
    logic [10:0] yw;
    yw = {5'd0, y};
    return (yw << 5) + (yw << 3) + {5'd0, x};
  endfunction

  state_t      state_q, state_d;
  logic [10:0] sweep_q;
  logic        vga_rd_q;
  logic [5:0]  nx_q, ny_q, tx_q, ty_q;
  logic        grow_q;

  logic [10:0] addr_c;
  logic        we_c, wdata_c;
  logic        same_cell, occupied;

  assign same_cell = (nx_q == tx_q) && (ny_q == ty_q);
  // A cell the tail leaves in this same move counts as free.
  assign occupied  = ram.ram_rdata & ~(same_cell & ~grow_q);
  assign step_done = (state_q == S_DONE);

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    addr_c  = '0;
    we_c    = 1'b0;
    wdata_c = 1'b0;
    unique case (state_q)
      S_INIT: begin
        addr_c = sweep_q;
        we_c   = 1'b1;
        if (sweep_q == SWEEP_LAST) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (step) state_d = (next_x >= X_LIMIT || next_y >= Y_LIMIT) ? S_DONE : S_RD;
      end
      S_RD: begin
        addr_c  = cell_addr(nx_q, ny_q);
        state_d = S_CHK;
      end
      // The read went out last cycle, so rdata is good even if VGA has just
      // taken the RAM back; CHK never stalls.
      S_CHK: state_d = occupied ? S_DONE : S_WR_HEAD;
      S_WR_HEAD: begin
        addr_c  = cell_addr(nx_q, ny_q);
        we_c    = 1'b1;
        wdata_c = 1'b1;
        state_d = grow_q ? S_DONE : S_CLR_TAIL;
      end
      S_CLR_TAIL: begin
        addr_c  = cell_addr(tx_q, ty_q);
        we_c    = ~same_cell;
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase

    // States that touch the RAM hold while VGA owns it.
    if (display_active && (state_q inside {S_INIT, S_RD, S_WR_HEAD, S_CLR_TAIL}))
      state_d = state_q;
    if (display_active) begin
      addr_c  = cell_addr(pixel_x, pixel_y);
      we_c    = 1'b0;
      wdata_c = 1'b0;
    end
    // Keep the RAM quiet while reset is held, so an aborted move writes nothing.
    if (!rst) begin
      addr_c  = '0;
      we_c    = 1'b0;
      wdata_c = 1'b0;
    end
  end

  assign ram.ram_addr  = addr_c;
  assign ram.ram_we    = we_c;
  assign ram.ram_wdata = wdata_c;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples values from before the clock edge.
  always_ff @(posedge clk_25M) begin
    if (!rst) begin
      state_q    <= S_INIT;
      sweep_q    <= '0;
      vga_rd_q   <= 1'b0;
      pixel_data <= 1'b0;
      init_done  <= 1'b0;
      busy       <= 1'b0;
      collide    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state_q  <= state_d;
      vga_rd_q <= display_active;
      if (vga_rd_q) pixel_data <= ram.ram_rdata;

      if (state_q == S_INIT && !display_active) begin
        sweep_q <= sweep_q + 11'd1;
        if (sweep_q == SWEEP_LAST) init_done <= 1'b1;
      end

      // busy stays high through DONE, so a step in the DONE cycle is dropped too.
      if (step && (busy || !init_done)) overrun <= 1'b1;

      if (state_q == S_IDLE && step) busy <= 1'b1;
      else if (state_q == S_DONE)    busy <= 1'b0;

      if (state_d == S_DONE && state_q != S_DONE)
        collide <= (state_q == S_IDLE) || (state_q == S_CHK);
    end
  end

  // NOTE: the move operands carry no reset; they are always loaded before use.
  always_ff @(posedge clk_25M) begin
    if (state_q == S_IDLE && step) begin
      nx_q   <= next_x;
      ny_q   <= next_y;
      tx_q   <= tail_x;
      ty_q   <= tail_y;
      grow_q <= grow;
    end
  end

endmodule

// File: tb/tb_grid_step_sequencer.sv
// ---------------------------------------------------------------------------
// tb_grid_step_sequencer
// Drives grid_step_sequencer with directed and $urandom moves against a
// cell-level model of the grid and the move rules. The bench also holds the
// single-port RAM (one-cycle read latency).
// ---------------------------------------------------------------------------
module tb_grid_step_sequencer;
  localparam int W = 40;
  localparam int H = 30;
  localparam int N = W * H;

  logic       clk_25M = 1'b0;
  logic       rst = 1'b0;
  logic       display_active = 1'b0;
  logic [5:0] pixel_x = '0, pixel_y = '0;
  logic       step = 1'b0, grow = 1'b0;
  logic [5:0] next_x = '0, next_y = '0, tail_x = '0, tail_y = '0;
  logic       pixel_data, init_done, busy, step_done, collide, overrun;

  grid_step_sequencer_if ram_if();

  grid_step_sequencer dut (
    .clk_25M        (clk_25M),
    .rst            (rst),
    .display_active (display_active),
    .pixel_x        (pixel_x),
    .pixel_y        (pixel_y),
    .pixel_data     (pixel_data),
    .step           (step),
    .next_x         (next_x),
    .next_y         (next_y),
    .tail_x         (tail_x),
    .tail_y         (tail_y),
    .grow           (grow),
    .ram            (ram_if),
    .init_done      (init_done),
    .busy           (busy),
    .step_done      (step_done),
    .collide        (collide),
    .overrun        (overrun)
  );

  always #20 clk_25M = ~clk_25M;

  // RAM starts full of ones so the clear sweep has something to clear.
  logic mem [N] = '{default: 1'b1};
  always @(posedge clk_25M) begin
    if (ram_if.ram_we && ram_if.ram_addr < 11'(N)) mem[ram_if.ram_addr] <= ram_if.ram_wdata;
    ram_if.ram_rdata <= (ram_if.ram_addr < 11'(N)) ? mem[ram_if.ram_addr] : 1'b0;
  end

  // Every RAM write, as {addr, data}.
  logic [11:0] wr_q[$];
  always @(posedge clk_25M) if (ram_if.ram_we) wr_q.push_back({ram_if.ram_addr, ram_if.ram_wdata});

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit          ref_grid [H][W];
  logic [11:0] exp_wr[$];
  bit          exp_col;
  int          exp_lat;
  int          wr_mark;

  function automatic logic [11:0] wr_entry(input int x, input int y, input bit d);
    return {11'(y * W + x), d};
  endfunction

  // Applies one move to the model grid; sets expected outcome, cycles from
  // step to step_done, and the list of RAM writes.
  task automatic model_move(input int nx, input int ny, input int tx, input int ty, input bit g);
    bit vacated;
    exp_wr.delete();
    if (nx >= W || ny >= H) begin
      exp_col = 1'b1; exp_lat = 1;
      return;
    end
    vacated = (nx == tx) && (ny == ty) && !g;
    if (ref_grid[ny][nx] && !vacated) begin
      exp_col = 1'b1; exp_lat = 3;
      return;
    end
    exp_col = 1'b0;
    ref_grid[ny][nx] = 1'b1;
    exp_wr.push_back(wr_entry(nx, ny, 1'b1));
    if (g) exp_lat = 4;
    else begin
      exp_lat = 5;
      if (!(nx == tx && ny == ty)) begin
        ref_grid[ty][tx] = 1'b0;
        exp_wr.push_back(wr_entry(tx, ty, 1'b0));
      end
    end
  endtask

  function automatic int grid_errors();
    int bad = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (mem[y * W + x] !== ref_grid[y][x]) bad++;
    return bad;
  endfunction

  // ---------------- stimulus helpers ----------------
  // Leaves the caller at the falling edge after the step was sampled.
  task automatic issue_step(input int nx, input int ny, input int tx, input int ty, input bit g);
    @(negedge clk_25M);
    next_x = 6'(nx); next_y = 6'(ny); tail_x = 6'(tx); tail_y = 6'(ty); grow = g;
    step = 1'b1;
    @(negedge clk_25M);
    step = 1'b0;
  endtask

  task automatic finish_move(input string tag, input int cyc0, input bit chk_lat, input bit poke_done);
    int cyc = cyc0;
    int n_wr;
    while (!step_done && cyc < 400) begin
      @(negedge clk_25M);
      cyc++;
    end
    check({tag, " step_done"}, 32'(step_done), 32'd1);
    if (!step_done) return;
    if (chk_lat) check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, " collide"}, 32'(collide), 32'(exp_col));
    n_wr = wr_q.size() - wr_mark;
    check({tag, " write count"}, 32'(n_wr), 32'(exp_wr.size()));
    if (n_wr == exp_wr.size())
      for (int i = 0; i < n_wr; i++) check({tag, " write"}, 32'(wr_q[wr_mark + i]), 32'(exp_wr[i]));
    if (poke_done) begin
      next_x = 6'd1; next_y = 6'd1; tail_x = 6'd2; tail_y = 6'd1; grow = 1'b0;
      step = 1'b1;
    end
    @(negedge clk_25M);
    step = 1'b0;
    check({tag, " pulse width"}, 32'(step_done), 32'd0);
    check({tag, " busy after"}, 32'(busy), 32'd0);
  endtask

  task automatic do_move(input int nx, input int ny, input int tx, input int ty, input bit g, input string tag);
    model_move(nx, ny, tx, ty, g);
    wr_mark = wr_q.size();
    issue_step(nx, ny, tx, ty, g);
    if (nx < W && ny < H) check({tag, " read addr"}, 32'(ram_if.ram_addr), 32'(ny * W + nx));
    finish_move(tag, 1, 1'b1, 1'b0);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, " init_done"}, 32'(init_done), 32'd0);
    check({tag, " busy"},      32'(busy),      32'd0);
    check({tag, " step_done"}, 32'(step_done), 32'd0);
    check({tag, " collide"},   32'(collide),   32'd0);
    check({tag, " overrun"},   32'(overrun),   32'd0);
    check({tag, " pixel_data"},32'(pixel_data),32'd0);
    check({tag, " ram_we"},    32'(ram_if.ram_we),    32'd0);
    check({tag, " ram_addr"},  32'(ram_if.ram_addr),  32'd0);
    check({tag, " ram_wdata"}, 32'(ram_if.ram_wdata), 32'd0);
  endtask

  // Releases reset and follows the clear sweep; optionally pokes a step
  // while the sweep is running.
  task automatic sweep(input string tag, input bit poke);
    int cyc = 0;
    int bad = 0;
    logic        prev_we = 1'b0;
    logic [10:0] prev_addr = '0;
    wr_mark = wr_q.size();
    rst = 1'b1;
    while (cyc < 1300) begin
      @(negedge clk_25M);
      cyc++;
      step = poke && (cyc == 10);
      if (init_done) break;
      prev_we = ram_if.ram_we;
      prev_addr = ram_if.ram_addr;
    end
    step = 1'b0;
    check({tag, " init_done"}, 32'(init_done), 32'd1);
    check({tag, " last write addr"}, 32'(prev_addr), 32'd1199);
    check({tag, " last write we"}, 32'(prev_we), 32'd1);
    check({tag, " write count"}, 32'(wr_q.size() - wr_mark), 32'd1200);
    if (wr_q.size() - wr_mark == 1200)
      for (int i = 0; i < 1200; i++) if (wr_q[wr_mark + i] != {11'(i), 1'b0}) bad++;
    check({tag, " sweep order"}, 32'(bad), 32'd0);
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) ref_grid[y][x] = 1'b0;
    check({tag, " grid clear"}, 32'(grid_errors()), 32'd0);
    check({tag, " overrun"}, 32'(overrun), 32'(poke));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lx = 5, ly = 3;
    int hx, hy, tx, ty, px, py, idx;
    bit g;
    bit exp_pix [100];

    repeat (3) @(negedge clk_25M);
    reset_checks("reset");
    sweep("init", 1'b0);

    // Directed moves and boundaries.
    do_move(5, 3, 4, 3, 1'b0, "move53");
    do_move(10, 10, 2, 2, 1'b1, "preload");
    do_move(10, 10, 2, 2, 1'b0, "hit");
    do_move(40, 0, 1, 1, 1'b0, "oor_x");
    do_move(0, 30, 1, 1, 1'b0, "oor_y");
    do_move(6, 3, 6, 3, 1'b0, "self_free");
    do_move(6, 3, 6, 3, 1'b0, "self_vacate");
    do_move(6, 3, 6, 3, 1'b1, "self_grow");
    do_move(39, 29, 0, 0, 1'b0, "corner");

    // Randomised moves, biased towards collisions and head==tail.
    for (int k = 0; k < 120; k++) begin
      tx = $urandom_range(0, W - 1);
      ty = $urandom_range(0, H - 1);
      g  = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 9))
        0: begin hx = $urandom_range(W, 63); hy = $urandom_range(0, H - 1); end
        1: begin hx = $urandom_range(0, W - 1); hy = $urandom_range(H, 63); end
        2, 3: begin hx = tx; hy = ty; end
        4, 5: begin hx = lx; hy = ly; end
        default: begin hx = $urandom_range(0, W - 1); hy = $urandom_range(0, H - 1); end
      endcase
      do_move(hx, hy, tx, ty, g, "rand");
      if (!exp_col) begin lx = hx; ly = hy; end
    end
    check("grid after random", 32'(grid_errors()), 32'd0);

    // VGA holds the RAM for 100 cycles while the move sits in WR_HEAD.
    idx = 600;
    while (ref_grid[idx / W][idx % W]) idx++;
    hx = idx % W; hy = idx / W;
    wr_mark = wr_q.size();
    issue_step(hx, hy, 0, 0, 1'b0);
    check("disp read addr", 32'(ram_if.ram_addr), 32'(hy * W + hx));
    @(negedge clk_25M);
    for (int i = 0; i < 100; i++) begin
      px = $urandom_range(0, W - 1);
      py = $urandom_range(0, H - 1);
      if ($urandom_range(0, 1) == 1)
        for (int j = 0; j < N; j++) begin
          int c = (py * W + px + j) % N;
          if (ref_grid[c / W][c % W]) begin px = c % W; py = c / W; break; end
        end
      exp_pix[i] = ref_grid[py][px];
      pixel_x = 6'(px); pixel_y = 6'(py); display_active = 1'b1;
      @(negedge clk_25M);
      check("disp ram_addr", 32'(ram_if.ram_addr), 32'(py * W + px));
      check("disp ram_we", 32'(ram_if.ram_we), 32'd0);
      if (i >= 1) check("disp pixel_data", 32'(pixel_data), 32'(exp_pix[i - 1]));
    end
    display_active = 1'b0;
    model_move(hx, hy, 0, 0, 1'b0);
    finish_move("disp", 0, 1'b0, 1'b0);

    // Second step while busy is dropped and flagged.
    check("overrun before", 32'(overrun), 32'd0);
    model_move(12, 4, 11, 4, 1'b0);
    wr_mark = wr_q.size();
    issue_step(12, 4, 11, 4, 1'b0);
    next_x = 6'd20; next_y = 6'd20; tail_x = 6'd12; tail_y = 6'd4; step = 1'b1;
    @(negedge clk_25M);
    step = 1'b0;
    finish_move("busy step", 2, 1'b1, 1'b0);
    check("overrun while busy", 32'(overrun), 32'd1);
    check("grid after overrun", 32'(grid_errors()), 32'd0);

    // Leave collide high, then reset in the middle of a head write.
    do_move(40, 40, 1, 1, 1'b0, "oor_xy");
    idx = 300;
    while (ref_grid[idx / W][idx % W]) idx++;
    wr_mark = wr_q.size();
    issue_step(idx % W, idx / W, 0, 0, 1'b0);
    @(negedge clk_25M);
    @(negedge clk_25M);
    rst = 1'b0;
    @(negedge clk_25M);
    reset_checks("midmove");
    check("midmove writes", 32'(wr_q.size() - wr_mark), 32'd0);
    sweep("resweep", 1'b1);

    // Step landing on the DONE pulse is dropped and flagged.
    rst = 1'b0;
    @(negedge clk_25M);
    sweep("resweep2", 1'b0);
    model_move(3, 3, 2, 3, 1'b0);
    wr_mark = wr_q.size();
    issue_step(3, 3, 2, 3, 1'b0);
    finish_move("done step", 1, 1'b1, 1'b1);
    wr_mark = wr_q.size();
    repeat (6) @(negedge clk_25M);
    check("done step overrun", 32'(overrun), 32'd1);
    check("done step ignored busy", 32'(busy), 32'd0);
    check("done step ignored writes", 32'(wr_q.size() - wr_mark), 32'd0);
    check("final grid", 32'(grid_errors()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Hard time limit in case a wait above is never satisfied.
  initial begin
    #20ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/grid_step_sequencer.md
Name: grid_step_sequencer

Overview:
Owns the single-port 1200-cell occupancy grid RAM (40x30, 1 bit per cell) and shares it between the VGA scan reader and the per-move game update. VGA reads have absolute priority during the active display region. The sequencer performs each move during blanking: read next-head occupancy, decide collision, write new head, clear old tail. After reset it sweeps the grid clear before accepting moves.

Parameters:
WIDTH, 40, grid columns
HEIGHT, 30, grid rows
CELLS, 1200, WIDTH*HEIGHT; RAM depth and init sweep length

Ports:
clk_25M  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-low reset
display_active  input  1  VGA active-region flag; 1 = VGA owns RAM this cycle
pixel_x  input  6  VGA cell column being scanned
pixel_y  input  6  VGA cell row being scanned
pixel_data  output  1  occupancy of scanned cell, registered
step  input  1  one-cycle move request, already synchronised to clk_25M
next_x  input  6  column of new head cell
next_y  input  6  row of new head cell
tail_x  input  6  column of current tail cell
tail_y  input  6  row of current tail cell
grow  input  1  apple eaten this move; tail is not cleared
ram_addr  output  11  RAM address = y*40 + x
ram_we  output  1  RAM write enable
ram_wdata  output  1  RAM write data
ram_rdata  input  1  RAM read data, valid one cycle after ram_addr
init_done  output  1  high once the clear sweep is complete
busy  output  1  move in progress
step_done  output  1  one-cycle pulse when a move finishes
collide  output  1  valid with step_done; 1 = move is fatal
overrun  output  1  sticky: step arrived while busy or before init_done

Behaviour:
- Reset values (rst low at a clock edge): state INIT, sweep counter 0, pixel_data 0, ram_we 0, ram_addr 0, ram_wdata 0, init_done 0, busy 0, step_done 0, collide 0, overrun 0.
- Reset asserted mid-operation aborts the move with no further writes. Any partial head write is wiped by the following INIT sweep.
- Address calculation: addr = (y<<5)+(y<<3)+x, 11 bits, maximum 1199.
- Arbitration: while display_active=1, ram_addr=addr(pixel_x,pixel_y) and ram_we=0, regardless of FSM state; the FSM stalls in place.
- pixel_data = ram_rdata registered on the cycle after a VGA read. Latency is 2 clk_25M from pixel_x/pixel_y to pixel_data. pixel_data holds its value during blanking.
- FSM states and transitions, each step taken only when display_active=0:
  - INIT: write 0 to the sweep counter address, increment. After address 1199: init_done<=1, go to IDLE.
  - IDLE: on step, busy<=1 and latch next_x, next_y, tail_x, tail_y, grow.
    - If next_x>=40 or next_y>=30: go to DONE with collide=1, no RAM access.
    - Otherwise go to RD.
  - RD: drive addr(next), then go to CHK.
  - CHK: sample ram_rdata unconditionally. The read was issued last cycle, so rdata is valid even if display_active has just risen.
    - occ = rdata & ~(next==tail & ~grow); a cell vacated by the tail in the same move is legal.
    - occ=1: go to DONE with collide=1.
    - occ=0: go to WR_HEAD.
  - WR_HEAD: we=1, wdata=1 at addr(next). Then go to CLR_TAIL if grow=0, else DONE.
  - CLR_TAIL: we=1, wdata=0 at addr(tail), unless tail==next, in which case skip the write. Then go to DONE.
  - DONE: step_done=1 for one cycle, collide valid, busy<=0, return to IDLE. DONE does not need the RAM, so it does not stall on display_active.
- Step handling:
  - step while busy=1 or init_done=0 is dropped and sets overrun<=1. overrun clears only on reset.
  - step arriving in the same cycle as the DONE pulse is also dropped and flagged.
- collide holds its last value until the next step_done.

Test Plan:
- Reset, display_active=0 -> exactly 1200 writes of 0 at addrs 0..1199. init_done rises the cycle after the addr-1199 write.
- After init, step with next=(5,3), tail=(4,3), grow=0, display_active=0 -> read addr 125, write 1 at 125, write 0 at 124, then step_done=1, collide=0. The move takes 5 cycles from step to step_done.
- Preload cell (10,10)=1, then step with next=(10,10), tail=(2,2) -> step_done with collide=1, no ram_we pulses.
- Step with next=(40,0) -> collide=1 with zero RAM accesses. Repeat with next=(0,30) -> same result.
- Hold display_active=1 for 100 cycles right after a step -> ram_we stays 0 throughout, and ram_addr tracks pixel addresses. The move completes after display_active falls, and pixel_data follows the RAM contents with 2-cycle latency.
- Issue a second step while busy -> overrun=1 and that step has no effect. Pulse rst low mid-move -> all outputs return to reset values and the INIT sweep restarts.
